mem_ctrl: RTL and testbench

- Memory-side responder for the core's word-level request interface.
- Serves two requesters: the load/store buffer port (mem_*) and the instruction-fetch port (if_*).
- Serialises each request into byte transfers on the single-port, byte-wide RAM/IO bus with one-cycle read latency.
- Returns assembled data with a single-cycle done pulse and honours IO back-pressure and rollback.

---
 rtl/mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serialising memory responder: arbitrates the LSB and fetch ports onto a
// byte-wide, one-cycle-latency RAM/IO bus and returns assembled words.
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_a,
    input  logic [2:0]        mem_l,
    input  logic [31:0]       mem_w,
    output logic [31:0]       mem_r,
    output logic              mem_done,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_a,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [1:0]        state;
    logic [2:0]        k;
    logic [2:0]        len;
    logic              port_if;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       buffer;
    logic [31:0]       buf_n;
    logic [2:0]        k_inc;
    logic [ADDR_W-1:0] addr_next;
    logic              io_stall;

    function automatic logic [2:0] norm_len(input logic [2:0] l);
        case (l)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [2:0] i);
        case (i)
            3'd0:    return d[7:0];
            3'd1:    return d[15:8];
            3'd2:    return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    assign k_inc     = k + 3'd1;
    assign addr_next = addr + {{(ADDR_W-3){1'b0}}, k_inc};
    assign io_stall  = (ram_a[17:16] == IO_SEL) && io_buffer_full;
    assign ram_wr    = (state == S_WR) && rdy && !io_stall;

    // In RD cycle k+1, ram_din carries the byte addressed in the previous cycle (index k-1).
    always_comb begin
        buf_n = buffer;
        case (k)
            3'd1:    buf_n[7:0]   = ram_din;
            3'd2:    buf_n[15:8]  = ram_din;
            3'd3:    buf_n[23:16] = ram_din;
            3'd4:    buf_n[31:24] = ram_din;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= 3'd0;
            len      <= 3'd0;
            port_if  <= 1'b0;
            addr     <= '0;
            data     <= 32'd0;
            buffer   <= 32'd0;
            ram_a    <= '0;
            ram_dout <= 8'd0;
            mem_r    <= 32'd0;
            mem_done <= 1'b0;
            if_data  <= 32'd0;
            if_done  <= 1'b0;
        end else if (rdy) begin
            mem_done <= 1'b0;
            if_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A done pulse marks the cycle the requester drops en; never accept then.
                    if (!mem_done && !if_done) begin
                        if (mem_en) begin
                            port_if <= 1'b0;
                            addr    <= mem_a;
                            len     <= norm_len(mem_l);
                            data    <= mem_w;
                            k       <= 3'd0;
                            buffer  <= 32'd0;
                            ram_a   <= mem_a;
                            if (mem_wr) begin
                                ram_dout <= mem_w[7:0];
                                state    <= S_WR;
                            end else begin
                                state <= S_RD;
                            end
                        end else if (if_en && !rollback) begin
                            port_if <= 1'b1;
                            addr    <= if_a;
                            len     <= 3'd4;
                            k       <= 3'd0;
                            buffer  <= 32'd0;
                            ram_a   <= if_a;
                            state   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (port_if && rollback) begin
                        state <= S_IDLE;
                    end else begin
                        buffer <= buf_n;
                        k      <= k_inc;
                        if (k_inc < len)
                            ram_a <= addr_next;
                        if (k == len) begin
                            state <= S_IDLE;
                            if (port_if) begin
                                if_done <= 1'b1;
                                if_data <= buf_n;
                            end else begin
                                mem_done <= 1'b1;
                                mem_r    <= buf_n;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (!io_stall) begin
                        if (k_inc == len) begin
                            mem_done <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            k        <= k_inc;
                            ram_a    <= addr_next;
                            ram_dout <= byte_of(data, k_inc);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide synchronous RAM model, per-cycle bus log
// and hand-computed expectations for loads, stores, arbitration, stalls and aborts.
module tb_mem_ctrl;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst, rdy, rollback;
    logic              mem_en, mem_wr;
    logic [ADDR_W-1:0] mem_a;
    logic [2:0]        mem_l;
    logic [31:0]       mem_w, mem_r;
    logic              mem_done;
    logic              if_en;
    logic [ADDR_W-1:0] if_a;
    logic [31:0]       if_data;
    logic              if_done;
    logic [7:0]        ram_din, ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              io_buffer_full;

    mem_ctrl #(.ADDR_W(ADDR_W), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_a(mem_a), .mem_l(mem_l),
        .mem_w(mem_w), .mem_r(mem_r), .mem_done(mem_done),
        .if_en(if_en), .if_a(if_a), .if_data(if_data), .if_done(if_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_m [0:262143];
    always @(posedge clk) begin
        if (ram_wr) ram_m[ram_a[17:0]] <= ram_dout;
        ram_din <= ram_m[ram_a[17:0]];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int                cyc, md_cnt, md_cyc, id_cnt, id_cyc;
    logic [31:0]       md_data, id_data;
    logic [ADDR_W-1:0] a_log [0:31];
    logic              wr_log [0:31];
    logic [7:0]        d_log [0:31];
    int                rb_cyc, full_lo, full_hi, rdy_off;

    // Cycle 0 is the cycle in which start() is called and the request is driven.
    task automatic start();
        cyc = 0; md_cnt = 0; md_cyc = -1; id_cnt = 0; id_cyc = -1;
        md_data = 32'd0; id_data = 32'd0;
        rb_cyc = -1; full_lo = 1; full_hi = 0; rdy_off = -1;
        for (int i = 0; i < 32; i++) begin
            a_log[i] = '0; wr_log[i] = 1'b0; d_log[i] = 8'd0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rollback = (cyc == rb_cyc);
        if (rollback) if_en = 1'b0;
        io_buffer_full = (cyc >= full_lo) && (cyc <= full_hi);
        rdy = (cyc != rdy_off);
        #1;
        if (cyc < 32) begin
            a_log[cyc] = ram_a; wr_log[cyc] = ram_wr; d_log[cyc] = ram_dout;
        end
        if (mem_done) begin
            md_cnt++; md_cyc = cyc; md_data = mem_r; mem_en = 1'b0;
        end
        if (if_done) begin
            id_cnt++; id_cyc = cyc; id_data = if_data; if_en = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lsb(input logic wr, input logic [31:0] a, input logic [2:0] l, input logic [31:0] w);
        mem_en = 1'b1; mem_wr = wr; mem_a = a; mem_l = l; mem_w = w;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ram_m[i] = 8'h00;
        ram_m[18'h100] = 8'h11; ram_m[18'h101] = 8'h22;
        ram_m[18'h102] = 8'h33; ram_m[18'h103] = 8'h44;
        ram_m[18'h206] = 8'h5A;
        ram_m[18'h010] = 8'h80;
        ram_m[18'h040] = 8'h01; ram_m[18'h041] = 8'h02;
        ram_m[18'h042] = 8'h03; ram_m[18'h043] = 8'h04;
        ram_m[18'h3FFFE] = 8'hAA; ram_m[18'h3FFFF] = 8'hBB;
        ram_m[18'h00000] = 8'hCC; ram_m[18'h00001] = 8'hDD;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        mem_en = 1'b0; mem_wr = 1'b0; mem_a = '0; mem_l = 3'd0; mem_w = 32'd0;
        if_en = 1'b0; if_a = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_done", {30'd0, mem_done, if_done}, 32'd0);
        check("rst_data", mem_r | if_data, 32'd0);
        rst = 1'b0;
        start(); run(1);

        // Load word
        start(); lsb(1'b0, 32'h100, 3'd4, 32'd0); run(8);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("ldw_a%0d", c), a_log[c], 32'h100 + c - 1);
            check($sformatf("ldw_wr%0d", c), {31'd0, wr_log[c]}, 32'd0);
        end
        check("ldw_done_cyc", md_cyc, 6);
        check("ldw_done_cnt", md_cnt, 1);
        check("ldw_data", md_data, 32'h44332211);

        // Store half
        start(); lsb(1'b1, 32'h204, 3'd2, 32'hDEADBEEF); run(6);
        check("sth_a1", a_log[1], 32'h204);
        check("sth_d1", {24'd0, d_log[1]}, 32'hEF);
        check("sth_wr1", {31'd0, wr_log[1]}, 32'd1);
        check("sth_a2", a_log[2], 32'h205);
        check("sth_d2", {24'd0, d_log[2]}, 32'hBE);
        check("sth_wr3", {31'd0, wr_log[3]}, 32'd0);
        check("sth_done_cyc", md_cyc, 3);
        check("sth_done_cnt", md_cnt, 1);
        check("sth_ram", {8'd0, ram_m[18'h204], ram_m[18'h205], ram_m[18'h206]}, 32'h00EFBE5A);
        mem_wr = 1'b0;

        // Arbitration: LSB first, fetch accepted the cycle after mem_done
        start(); lsb(1'b0, 32'h10, 3'd1, 32'd0); if_en = 1'b1; if_a = 32'h40; run(13);
        check("arb_a1", a_log[1], 32'h10);
        check("arb_md_cyc", md_cyc, 3);
        check("arb_md_data", md_data, 32'h00000080);
        check("arb_fetch_a", a_log[5], 32'h40);
        check("arb_id_cyc", id_cyc, 10);
        check("arb_id_cnt", id_cnt, 1);
        check("arb_id_data", id_data, 32'h04030201);

        // IO write stall for three cycles
        start(); lsb(1'b1, 32'h30000, 3'd1, 32'h41); full_hi = 3; run(7);
        check("io_wr_stall", {29'd0, wr_log[1], wr_log[2], wr_log[3]}, 32'd0);
        check("io_wr4", {31'd0, wr_log[4]}, 32'd1);
        check("io_a4", a_log[4], 32'h30000);
        check("io_done_cyc", md_cyc, 5);
        check("io_ram", {24'd0, ram_m[18'h30000]}, 32'h41);
        mem_wr = 1'b0;

        // Rollback aborts an in-flight fetch
        start(); if_en = 1'b1; if_a = 32'h40; rb_cyc = 3; run(10);
        check("rb_if_cnt", id_cnt, 0);
        check("rb_a_frozen", a_log[5], 32'h42);

        // Rollback does not affect an LSB load
        start(); lsb(1'b0, 32'h100, 3'd2, 32'd0); rb_cyc = 2; run(7);
        check("rb_lsb_cyc", md_cyc, 4);
        check("rb_lsb_data", md_data, 32'h00002211);

        // Rollback blocks a fetch in the sampling cycle; concurrent LSB still accepted
        start(); lsb(1'b0, 32'h10, 3'd1, 32'd0); if_en = 1'b1; if_a = 32'h40; rollback = 1'b1;
        step(); if_en = 1'b0; run(10);
        check("rb0_md_data", md_data, 32'h00000080);
        check("rb0_md_cyc", md_cyc, 3);
        check("rb0_if_cnt", id_cnt, 0);

        // Address wrap with illegal length 3 treated as 4
        start(); lsb(1'b0, 32'hFFFFFFFE, 3'd3, 32'd0); run(8);
        check("wrap_a3", a_log[3], 32'h0);
        check("wrap_done_cyc", md_cyc, 6);
        check("wrap_data", md_data, 32'hDDCCBBAA);

        // rdy low for one cycle stretches a byte load by one cycle
        start(); lsb(1'b0, 32'h10, 3'd1, 32'd0); rdy_off = 2; run(6);
        check("rdy_done_cyc", md_cyc, 4);
        check("rdy_data", md_data, 32'h00000080);

        // Reset after the first byte of a word store
        start(); lsb(1'b1, 32'h300, 3'd4, 32'hA1B2C3D4); step();
        check("rs_wr1", {23'd0, wr_log[1], d_log[1]}, 32'h1D4);
        rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0;
        step();
        check("rs_outs", {ram_a[23:0], ram_dout}, 32'd0);
        check("rs_wr_done", {30'd0, ram_wr, mem_done}, 32'd0);
        rst = 1'b0;
        run(6);
        check("rs_no_done", md_cnt, 0);
        check("rs_ram", {16'd0, ram_m[18'h300], ram_m[18'h301]}, 32'h0000D400);
        start(); lsb(1'b0, 32'h100, 3'd4, 32'd0); run(8);
        check("rs_next_cyc", md_cyc, 6);
        check("rs_next_data", md_data, 32'h44332211);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
